// File: rtl/timer_loader_pkg.sv
// Shared types and constants for the microwave timer front-end controller.
package timer_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        ABORT = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int BCD_W   = 4;
    localparam int ENTRY_W = 16;
    // Wide enough for the 4-digit MM:SS entry count (0..4).
    localparam int CNT_W   = 3;

    localparam logic [ENTRY_W-1:0] QUICK_TIME   = 16'h0030;
    localparam logic [BCD_W-1:0]   SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/timer_loader_if.sv
// Keypad/countdown-chain signal bundle for timer_loader, plus debug state and digit count.
interface timer_loader_if;
    import timer_loader_pkg::*;

    logic [BCD_W-1:0]   digit;
    logic               digit_valid;
    logic               start;
    logic               stop;
    logic               cancel;
    logic               zero;
    logic [ENTRY_W-1:0] load_data;
    logic               loadn;
    logic               en;
    logic [ENTRY_W-1:0] entry;
    logic               err;
    logic               beep;
    state_e             state;
    logic [CNT_W-1:0]   count;

    // Key inputs are single-cycle pulses sampled on the rising clock edge; no back-pressure.
    modport master (
        output digit, digit_valid, start, stop, cancel, zero,
        input  load_data, loadn, en, entry, err, beep, state, count
    );

    modport slave (
        input  digit, digit_valid, start, stop, cancel, zero,
        output load_data, loadn, en, entry, err, beep, state, count
    );

endinterface

// File: rtl/timer_loader_bcd_entry_shifter.sv
// Keypad entry register: accepts valid BCD digits, shifts them into MM:SS, counts them.
module bcd_entry_shifter
    import timer_loader_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [BCD_W-1:0]   digit,
    input  logic               digit_valid,
    input  logic               enable,
    input  logic               clear,
    output logic [ENTRY_W-1:0] entry,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               accept;

    always_comb begin
        accept  = enable && digit_valid && (digit <= BCD_W'(9)) &&
                  (count_q < CNT_W'(MAX_DIGITS));
        entry_d = entry_q;
        count_d = count_q;
        if (clear) begin
            entry_d = '0;
            count_d = '0;
        end else if (accept) begin
            entry_d = {entry_q[ENTRY_W-BCD_W-1:0], digit};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            entry_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign entry = entry_q;
    assign count = count_q;

endmodule

// File: rtl/timer_loader.sv
// Microwave timer front-end: keypad entry, validation, load/enable of the countdown chain.
// Optional build macro TIMER_LOADER_QUICKSTART_EN: start on an empty entry loads 00:30.
module timer_loader
    import timer_loader_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int BEEP_CYCLES = 3
) (
    input logic           clk,
    input logic           clrn,
    timer_loader_if.slave bus
);

    localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
    logic [ENTRY_W-1:0] load_data_q, load_data_d;
    logic               loadn_q, loadn_d;
    logic               en_q, en_d;
    logic               err_q, err_d;
    logic               beep_q, beep_d;
    logic               clear;
    logic [ENTRY_W-1:0] entry;
    logic [CNT_W-1:0]   count;

    bcd_entry_shifter #(.MAX_DIGITS(MAX_DIGITS)) u_entry (
        .clk         (clk),
        .clrn        (clrn),
        .digit       (bus.digit),
        .digit_valid (bus.digit_valid),
        .enable      (state_q == IDLE),
        .clear       (clear),
        .entry       (entry),
        .count       (count)
    );

    always_comb begin
        state_d     = state_q;
        beep_cnt_d  = beep_cnt_q;
        load_data_d = load_data_q;
        err_d       = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    clear = 1'b1;
                end else if (bus.start) begin
                    if (entry == '0) begin
`ifdef TIMER_LOADER_QUICKSTART_EN
                        state_d     = LOAD;
                        load_data_d = QUICK_TIME;
`endif
                    end else if (entry[7:4] > SEC_TENS_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        load_data_d = entry;
                    end
                end
            end
            LOAD: begin
                clear   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = ABORT;
                end else if (bus.zero) begin
                    state_d    = DONE;
                    beep_cnt_d = BEEP_W'(BEEP_CYCLES - 1);
                end else if (bus.stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.stop || bus.cancel) begin
                    state_d = ABORT;
                end else if (bus.start) begin
                    state_d = RUN;
                end
            end
            ABORT: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
            DONE: begin
                if (bus.cancel || (beep_cnt_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q - BEEP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        loadn_d = !((state_d == LOAD) || (state_d == ABORT));
        en_d    = (state_d == RUN);
        beep_d  = (state_d == DONE);
        if (state_d == ABORT) begin
            load_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            beep_cnt_q  <= '0;
            load_data_q <= '0;
            loadn_q     <= 1'b1;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beep_cnt_q  <= beep_cnt_d;
            load_data_q <= load_data_d;
            loadn_q     <= loadn_d;
            en_q        <= en_d;
            err_q       <= err_d;
            beep_q      <= beep_d;
        end
    end

    assign bus.load_data = load_data_q;
    assign bus.loadn     = loadn_q;
    assign bus.en        = en_q;
    assign bus.err       = err_q;
    assign bus.beep      = beep_q;
    assign bus.entry     = entry;
    assign bus.state     = state_q;
    assign bus.count     = count;

endmodule
